// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   irq_state_t : controller FSM states
//   IRQ_N       : number of interrupt sources
//   IRQ_IDX_W   : width of a source index
//   MCAUSE_INT  : interrupt flag bit of mcause
package irq_pkg;

    localparam int          IRQ_N      = 32;
    localparam int          IRQ_IDX_W  = 5;
    localparam logic [31:0] MCAUSE_INT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FIN   = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_ctrl_rr_arbiter.sv
// Combinational round-robin picker.
//   req   in  IRQ_N      request vector (already masked)
//   ptr   in  IRQ_IDX_W  index searched first; search wraps modulo IRQ_N
//   valid out 1          any request set
//   idx   out IRQ_IDX_W  first set request at or after ptr
module rr_arbiter
    import irq_pkg::*;
(
    input  logic [IRQ_N-1:0]     req,
    input  logic [IRQ_IDX_W-1:0] ptr,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    logic [2*IRQ_N-1:0]   req_dbl;
    logic [IRQ_N-1:0]     req_rot;
    logic [IRQ_IDX_W-1:0] offset;

    // Shifting the doubled vector right by ptr rotates bit ptr into bit 0,
    // so a plain lowest-bit priority encoder gives the distance from ptr.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[IRQ_N-1:0];

    always_comb begin
        offset = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IRQ_IDX_W'(i);
            end
        end
    end

    assign valid = |req;
    // Wraps naturally in IRQ_IDX_W bits.
    assign idx   = ptr + offset;

endmodule

// File: rtl/irq_ctrl.sv
// Round-robin interrupt controller between peripheral request buses and the core.
//   clk_i      in  1   system clock
//   rst_i      in  1   asynchronous active-high reset
//   int_req_i  in  32  level requests, bit i = source i
//   mie_i      in  32  per-source enable mask
//   int_rst_i  in  1   mret-retired pulse from the core
//   int_o      out 1   one-cycle interrupt pulse
//   mcause_o   out 32  cause of granted source, held through SERVE and FIN
//   int_fin_o  out 32  one-hot one-cycle finish strobe to the granted source
//
// state | meaning
// IDLE  | arbitrate masked requests each cycle
// SERVE | core is handling grant; wait for int_rst_i
// FIN   | strobe int_fin_o, advance ptr, give source a clock to drop its request
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int CAUSE_BASE = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] int_req_i,
    input  logic [31:0] mie_i,
    input  logic        int_rst_i,
    output logic        int_o,
    output logic [31:0] mcause_o,
    output logic [31:0] int_fin_o
);

    localparam logic [5:0] CAUSE_BASE_6 = 6'(CAUSE_BASE);

    irq_state_t           state;
    logic [IRQ_IDX_W-1:0] ptr;
    logic [IRQ_IDX_W-1:0] grant;
    logic [IRQ_N-1:0]     pending;
    logic                 pick_valid;
    logic [IRQ_IDX_W-1:0] pick_idx;
    logic [5:0]           cause_code;

    assign pending = int_req_i & mie_i;

    rr_arbiter u_arb (
        .req   (pending),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            int_o <= 1'b0;
        end else begin
            int_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        int_o <= 1'b1;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (int_rst_i) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // Next search starts just past the source just served.
                    ptr   <= grant + 5'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Six-bit sum, zero-extended into the low bits of mcause.
    assign cause_code = CAUSE_BASE_6 + {1'b0, grant};

    always_comb begin
        mcause_o  = '0;
        int_fin_o = '0;
        if (state != IDLE) begin
            mcause_o = MCAUSE_INT | {26'd0, cause_code};
        end
        if (state == FIN) begin
            int_fin_o = 32'd1 << grant;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table of services plus hand-written
// sequences for masking, round-robin fairness, and reset mid-service.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] int_req;
    logic [31:0] mie;
    logic        int_rst;
    logic        int_irq;
    logic [31:0] mcause;
    logic [31:0] int_fin;

    int checks = 0;
    int errors = 0;
    int n_int  = 0;
    int exp_q[$];
    int cur_grant = 0;
    bit in_service = 1'b0;

    typedef struct {
        logic [31:0] req;
        logic [31:0] en;
        int          idx;
        bit          drop;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    irq_ctrl #(.CAUSE_BASE(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .int_req_i (int_req),
        .mie_i     (mie),
        .int_rst_i (int_rst),
        .int_o     (int_irq),
        .mcause_o  (mcause),
        .int_fin_o (int_fin)
    );

    function automatic logic [31:0] cause_of(int idx);
        return 32'h8000_0000 | 32'(16 + idx);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every int_o pops the grant the stimulus predicted; every
    // int_fin_o must match the grant currently in service.
    always @(negedge clk) begin
        if (rst) begin
            in_service = 1'b0;
        end else begin
            if (int_irq) begin
                n_int++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_int_o: got int_o with mcause %h, expected no interrupt", mcause);
                end else begin
                    cur_grant = exp_q.pop_front();
                    check("grant_mcause", mcause, cause_of(cur_grant));
                    in_service = 1'b1;
                end
            end
            if (int_fin != 32'd0) begin
                if (!in_service) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_int_fin: got %h, expected 0", int_fin);
                end else begin
                    check("int_fin", int_fin, 32'd1 << cur_grant);
                    in_service = 1'b0;
                end
            end
        end
    end

    task automatic wait_int(output bit ok);
        int dummy;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (int_irq) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL int_o_timeout: got no int_o within 20 cycles, expected one");
            if (exp_q.size() > 0) dummy = exp_q.pop_back();
        end
    endtask

    // One full service: present request, await grant, acknowledge with mret,
    // and (if clear) drop the request on the edge after int_fin_o like a peripheral.
    task automatic serve(logic [31:0] req, logic [31:0] en, int idx, bit drop, bit clear);
        bit ok;
        @(posedge clk); #1;
        int_req = req;
        mie     = en;
        exp_q.push_back(idx);
        wait_int(ok);
        if (!ok) return;
        if (drop) int_req = 32'd0;
        @(negedge clk);
        check("int_o_one_cycle", {31'd0, int_irq}, 32'd0);
        check("mcause_hold_serve", mcause, cause_of(idx));
        @(posedge clk); #1 int_rst = 1'b1;
        @(posedge clk); #1 int_rst = 1'b0;
        @(negedge clk);
        check("mcause_hold_fin", mcause, cause_of(idx));
        @(posedge clk); #1;
        if (clear) int_req = 32'd0;
        @(negedge clk);
        check("idle_mcause", mcause, 32'd0);
        check("idle_fin", int_fin, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;

        vecs[0]  = '{32'h0000_0001, 32'h0000_0001,  0, 1'b0};
        vecs[1]  = '{32'h0000_0008, 32'hFFFF_FFFF,  3, 1'b0};
        vecs[2]  = '{32'h0000_0005, 32'hFFFF_FFFF,  0, 1'b0};
        vecs[3]  = '{32'h0000_0005, 32'hFFFF_FFFF,  2, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 31, 1'b0};
        vecs[5]  = '{32'h8000_0001, 32'hFFFF_FFFF,  0, 1'b0};
        vecs[6]  = '{32'hFFFF_0000, 32'h00F0_0000, 20, 1'b1};
        vecs[7]  = '{32'h0010_0002, 32'hFFFF_FFFF,  1, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  2, 1'b0};
        vecs[9]  = '{32'h4000_0004, 32'hFFFF_FFFF, 30, 1'b0};
        vecs[10] = '{32'h0000_0004, 32'hFFFF_FFFF,  2, 1'b0};
        vecs[11] = '{32'h0000_0002, 32'hFFFF_FFFF,  1, 1'b0};

        rst = 1'b1; int_req = 32'd0; mie = 32'd0; int_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_int_o", {31'd0, int_irq}, 32'd0);
        check("reset_mcause", mcause, 32'd0);
        check("reset_fin", int_fin, 32'd0);
        rst = 1'b0;

        // Masked request, plus an mret pulse in IDLE: nothing must happen.
        @(posedge clk); #1;
        int_req = 32'h0000_0008;
        mie     = 32'd0;
        @(posedge clk); #1 int_rst = 1'b1;
        @(posedge clk); #1 int_rst = 1'b0;
        repeat (20) @(negedge clk);
        check("masked_no_int", 32'(n_int), 32'd0);
        serve(32'h0000_0008, 32'h0000_0008, 3, 1'b0, 1'b1);

        // Vector table; ptr carries over from row to row.
        foreach (vecs[i]) begin
            serve(vecs[i].req, vecs[i].en, vecs[i].idx, vecs[i].drop, 1'b1);
        end
        repeat (10) @(negedge clk);
        check("int_count_table", 32'(n_int), 32'd13);

        // Reset returns ptr to 0 (it was 2), then held 0x5 alternates 0,2,0,2.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        serve(32'h0000_0005, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        serve(32'h0000_0005, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);
        serve(32'h0000_0005, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        serve(32'h0000_0005, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);

        // Reset mid-service on grant 5: outputs clear at once, no finish strobe.
        @(posedge clk); #1;
        int_req = 32'h0000_0020;
        mie     = 32'hFFFF_FFFF;
        exp_q.push_back(5);
        wait_int(ok);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_int_o", {31'd0, int_irq}, 32'd0);
        check("midrst_mcause", mcause, 32'd0);
        check("midrst_fin", int_fin, 32'd0);
        @(posedge clk); #1;
        check("midrst_fin_hold", int_fin, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        serve(32'h0000_0020, 32'hFFFF_FFFF, 5, 1'b0, 1'b1);

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("int_count_total", 32'(n_int), 32'd19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
